// File: rtl/parity_pkg.sv
// parity_pkg: shared types and defaults for the parity checker/generator family.
//   par_mode_e  - per-beat parity mode (PAR_EVEN = 0, PAR_ODD = 1)
//   DATA_W_DEF  - default data word width
//   CNT_W_DEF   - default error counter width
package parity_pkg;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/parity_calc.sv
// parity_calc: purely combinational parity check of one word plus its parity bit.
// Shared with the generator side, so it carries no state.
// Ports:
//   data   [DATA_W-1:0] in  - data word
//   parity              in  - received parity bit
//   odd                 in  - 0 = even parity expected, 1 = odd
//   err                 out - 1 when the total count of ones breaks the chosen mode
module parity_calc
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data,
    input  logic              parity,
    input  logic              odd,
    output logic              err
);

    // Reduction XOR gives 1 for an odd number of ones; odd mode inverts the verdict.
    function automatic logic calc_err(
        input logic [DATA_W-1:0] d,
        input logic              p,
        input par_mode_e         m
    );
        logic odd_ones;
        odd_ones = ^{p, d};
        return odd_ones ^ (m == PAR_ODD);
    endfunction

    par_mode_e mode_s;

    assign mode_s = par_mode_e'(odd);
    assign err    = calc_err(data, parity, mode_s);

endmodule

// File: rtl/parity_stream_checker.sv
// parity_stream_checker: one-stage valid/ready pipeline that checks each word
// against even/odd parity (chosen per beat) and forwards it with an error flag.
// Link health is exposed as a saturating error counter and a sticky error flag.
// Optional feature macro: PARITY_CHK_ERRCNT_EN
//   defined     - err_count is a saturating counter of errored accepted beats
//   not defined - counter removed, err_count tied to 0, clr clears only err_sticky
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_data/in_parity/in_odd  - input beat
//   out_valid/out_ready/out_data/out_err         - output beat (registered)
//   clr                                          - sync clear of err_count/err_sticky
//   err_count, err_sticky                        - link health (registered)
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    input  logic              clr,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky
);

    logic              err_s;
    logic              accept_s;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_err_r;
    logic              err_sticky_r;

    parity_calc #(
        .DATA_W (DATA_W)
    ) u_calc (
        .data   (in_data),
        .parity (in_parity),
        .odd    (in_odd),
        .err    (err_s)
    );

    // Single register stage: a slot frees up when empty or draining this cycle.
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Output stage register: load on accept, drop valid on a plain transfer, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_err_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data;
            out_err_r   <= err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky flag: a new error wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
        end else if (accept_s && err_s) begin
            err_sticky_r <= 1'b1;
        end else if (clr) begin
            err_sticky_r <= 1'b0;
        end else begin
            err_sticky_r <= err_sticky_r;
        end
    end

`ifdef PARITY_CHK_ERRCNT_EN
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_base_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Next count: clear first, then count the new error so a collision yields 1.
    always_comb begin
        cnt_base_s = cnt_r;
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_base_s = {CNT_W{1'b0}};
        end else begin
            cnt_base_s = cnt_r;
        end
        if (accept_s && err_s && (cnt_base_s != {CNT_W{1'b1}})) begin
            cnt_next_s = cnt_base_s + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_base_s;
        end
    end

    // Error counter register, updated on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign err_count = cnt_r;
`else
    assign err_count = {CNT_W{1'b0}};
`endif

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_err    = out_err_r;
    assign err_sticky = err_sticky_r;

endmodule

// File: doc/parity_stream_checker.md
# parity_stream_checker

Streaming parity checker: accepts DATA_W-bit words, each with a parity bit, over a valid/ready handshake. Each word is checked against even or odd parity, chosen per beat, and forwarded one cycle later with an error flag. A saturating error counter and a sticky error flag give software-visible link health. It is the parametrised, pipelined successor of the 2-bit combinational even-parity checker and sits between a serial deframer and downstream consumers.

## Interface
- DATA_W, 8, data word width (≥1)
- CNT_W, 16, error counter width (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_W  data word
- in_parity  in  1  received parity bit
- in_odd  in  1  0 = even parity expected, 1 = odd, sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  registered copy of in_data
- out_err  out  1  parity error for this beat
- clr  in  1  synchronous clear of err_count and err_sticky
- err_count  out  CNT_W  saturating count of erroneous accepted beats
- err_sticky  out  1  set on any error, held until clr or rst

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready (single register stage; full throughput, combinational ready path).
- Error condition: err = (^{in_parity, in_data}) ^ in_odd.
  - Even mode: total count of ones must be even.
  - Odd mode: total count of ones must be odd.
- On accept: the stage loads out_data, out_err = err and out_valid = 1.
- If out_valid && out_ready and there is no accept, out_valid goes to 0.
- While out_valid && !out_ready: out_data and out_err hold stable and in_ready = 0.
- Counting: err_count increments once per accepted beat with err = 1, at acceptance time, not output transfer time.
  - It saturates at 2^CNT_W−1 and never wraps.
- err_sticky is set on any accepted errored beat.
- clr = 1 clears err_count and err_sticky. If an errored beat is accepted in the same cycle, the result is err_count = 1 and err_sticky = 1, because the new error is counted after the clear.
- Beats with in_valid = 0 never affect the counter, regardless of data.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_err = 0, err_count = 0, err_sticky = 0.
- in_ready = 1 after reset.
- Latency: 1 cycle, from accept edge to out_valid.
- Counter and sticky update on the same edge as the accept.
- rst asserted mid-operation: the pending output beat is discarded, all state returns to reset values immediately, and no partial beat is emitted.
- Back-to-back beats with out_ready held at 1: one beat per cycle, no bubbles.

## Configuration
- PARITY_CHK_ERRCNT_EN defined: err_count is implemented as above.
- PARITY_CHK_ERRCNT_EN not defined:
  - The counter register is removed and err_count is tied to 0.
  - err_sticky, out_err and the handshake are unchanged.
  - clr affects only err_sticky.

## Structure
- Package parity_pkg holds:
  - the parity-mode typedef (PAR_EVEN = 0, PAR_ODD = 1);
  - default constants DATA_W_DEF = 8 and CNT_W_DEF = 16.
- One sub-module, parity_calc: purely combinational, parameter DATA_W, inputs data/parity/odd, output err.
  - It is reused later by the generator side.
- The top level holds the register stage, handshake and counter.

## Test plan
- Even mode, clean beat: in_data = 8'hA5 (four ones), in_parity = 0, in_odd = 0.
  - Next cycle: out_valid = 1, out_data = A5, out_err = 0; err_count stays 0.
- Odd-mode error: in_data = 8'h0F, in_parity = 0, in_odd = 1.
  - Next cycle: out_err = 1; err_count = 1, err_sticky = 1.
- Backpressure: hold out_ready = 0 with two beats offered.
  - in_ready = 0 after the first accept, and the first beat holds stable.
  - Release out_ready: the second beat is accepted in the same cycle, so there is no loss and no duplication.
- Saturation: CNT_W = 2, send 5 errored beats.
  - err_count reads 1, 2, 3, 3, 3.
- Clear collision: with err_count = 3, assert clr in the same cycle as an accepted errored beat.
  - err_count = 1 and err_sticky = 1 on the next cycle.
- Reset mid-beat: assert rst while out_valid = 1 and out_ready = 0.
  - Immediately out_valid = 0, err_count = 0 and err_sticky = 0.
  - With PARITY_CHK_ERRCNT_EN undefined, err_count is always 0.
